// File: rtl/r6x_gfx_pkg.sv
// Shared types and defaults for the RISC6 graphics front end.
package r6x_gfx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StEmit  = 2'd3
  } disp_state_e;

  localparam int unsigned DefPixW    = 8;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned TmoCntW    = 16;

endpackage

// File: rtl/shader_dispatch_if.sv
// Stream, shader start/done and status bundle around the shader dispatcher.
interface shader_dispatch_if
  import r6x_gfx_pkg::*;
#(
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned CNT_W = 16
);
  logic             src_valid;
  logic             src_ready;
  logic [PIX_W-1:0] src_pixel;
  logic             src_last;
  logic             shd_start;
  logic [PIX_W-1:0] shd_pixel;
  logic             shd_done;
  logic [PIX_W-1:0] shd_result;
  logic             dst_valid;
  logic             dst_ready;
  logic [PIX_W-1:0] dst_pixel;
  logic             dst_last;
  logic             err_timeout;
  logic             err_clr;
  logic [CNT_W-1:0] pix_count;

  // master is the dispatcher, slave is the surrounding fetch/shader/line-buffer side
  modport master (
    input  src_valid, src_pixel, src_last, shd_done, shd_result, dst_ready, err_clr,
    output src_ready, shd_start, shd_pixel, dst_valid, dst_pixel, dst_last, err_timeout,
    output pix_count
  );

  modport slave (
    output src_valid, src_pixel, src_last, shd_done, shd_result, dst_ready, err_clr,
    input  src_ready, shd_start, shd_pixel, dst_valid, dst_pixel, dst_last, err_timeout,
    input  pix_count
  );

endinterface

// File: rtl/shader_dispatch.sv
// Issues one pixel at a time to the shader, waits for done with a timeout guard,
// and forwards the shaded (or original, on timeout) pixel downstream.
module shader_dispatch
  import r6x_gfx_pkg::*;
#(
  parameter int unsigned PIX_W   = DefPixW,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  shader_dispatch_if.master bus
);

  localparam logic [TmoCntW-1:0] TmoLast = TmoCntW'(TIMEOUT - 1);

  disp_state_e        r_state, w_state_d;
  logic [TmoCntW-1:0] r_tmo_cnt;
  logic [PIX_W-1:0]   r_src_pixel, r_dst_pixel;
  logic               r_src_last, r_dst_last;
  logic               r_shd_start, r_dst_valid, r_err;
  logic [CNT_W-1:0]   r_pix_count;
  logic               w_accept, w_done, w_timeout, w_emit_hs;
  logic               w_shd_start_d, w_dst_valid_d;

  assign w_accept  = (r_state == StIdle) && bus.src_valid;
  // done is only looked at in WAIT, so a held done from the last pixel is skipped in ISSUE
  assign w_done    = (r_state == StWait) && bus.shd_done;
  assign w_timeout = (r_state == StWait) && !bus.shd_done && (r_tmo_cnt == TmoLast);
  assign w_emit_hs = (r_state == StEmit) && bus.dst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.src_valid) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (w_done || w_timeout) w_state_d = StEmit;
      StEmit:  if (bus.dst_ready) w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_shd_start_d = (w_state_d == StIssue);
    w_dst_valid_d = (w_state_d == StEmit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_start <= 1'b0;
      r_dst_valid <= 1'b0;
    end else begin
      r_shd_start <= w_shd_start_d;
      r_dst_valid <= w_dst_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_pixel <= '0;
      r_src_last  <= 1'b0;
      r_tmo_cnt   <= '0;
      r_dst_pixel <= '0;
      r_dst_last  <= 1'b0;
      r_err       <= 1'b0;
      r_pix_count <= '0;
    end else begin
      if (w_accept) begin
        r_src_pixel <= bus.src_pixel;
        r_src_last  <= bus.src_last;
      end
      if (r_state == StIssue) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == StWait) && !bus.shd_done) begin
        r_tmo_cnt <= r_tmo_cnt + TmoCntW'(1);
      end
      if (w_done) begin
        r_dst_pixel <= bus.shd_result;
        r_dst_last  <= r_src_last;
      end else if (w_timeout) begin
        r_dst_pixel <= r_src_pixel;
        r_dst_last  <= r_src_last;
      end
      // a timeout in the same cycle as err_clr leaves the flag set
      if (w_timeout)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;
      if (w_emit_hs) r_pix_count <= r_pix_count + CNT_W'(1);
    end
  end

  assign bus.src_ready   = (r_state == StIdle);
  assign bus.shd_start   = r_shd_start;
  assign bus.shd_pixel   = r_src_pixel;
  assign bus.dst_valid   = r_dst_valid;
  assign bus.dst_pixel   = r_dst_pixel;
  assign bus.dst_last    = r_dst_last;
  assign bus.err_timeout = r_err;
  assign bus.pix_count   = r_pix_count;

endmodule

// File: doc/shader_dispatch.md
# shader_dispatch

Front end driving one RISC6 `shader_unit` per pixel. It accepts pixels from the scan-out fetch stream over a valid/ready handshake and issues each one to the shader with a single-cycle start pulse. It waits for the shader's done, with a timeout guard, then presents the shaded pixel on a valid/ready output stream toward the VGA line buffer. It owns the start side of the start/done protocol that `shader_unit` answers.

## Interface
Parameters:
- `PIX_W`, 8: pixel width; must match `shader_unit` pixel width.
- `TIMEOUT`, 64: maximum cycles in WAIT before the original pixel is forwarded unshaded. Range 2..65535.
- `CNT_W`, 16: width of the emitted-pixel counter.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `src_valid`  in  1  input pixel available.
- `src_ready`  out  1  dispatcher accepts input this cycle.
- `src_pixel`  in  PIX_W  input pixel.
- `src_last`  in  1  last pixel of line.
- `shd_start`  out  1  one-cycle start pulse to the shader.
- `shd_pixel`  out  PIX_W  pixel to the shader; stable from start until completion.
- `shd_done`  in  1  shader completion.
- `shd_result`  in  PIX_W  shaded pixel; valid while `shd_done`=1.
- `dst_valid`  out  1  output pixel available.
- `dst_ready`  in  1  downstream accepts.
- `dst_pixel`  out  PIX_W  output pixel.
- `dst_last`  out  1  last flag carried from input.
- `err_timeout`  out  1  sticky; set on any timeout.
- `err_clr`  in  1  clears `err_timeout`.
- `pix_count`  out  CNT_W  number of pixels emitted; wraps modulo 2^CNT_W.

## Operation
FSM states: IDLE, ISSUE, WAIT, EMIT.
- **IDLE:**
  - `src_ready`=1.
  - On `src_valid`, capture the pixel and last flag, then go to ISSUE.
- **ISSUE:**
  - `shd_start`=1 for exactly one cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT:**
  - `shd_done` is sampled only in WAIT, never in the ISSUE cycle. A stale or held `shd_done` from the previous pixel is therefore ignored for one cycle.
  - If `shd_done`=1, capture `shd_result` into the output register and go to EMIT.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without done, load the captured original pixel into the output register, set `err_timeout`, and go to EMIT.
  - If done and timeout occur in the same cycle, done wins: use the shaded result and do not set the error.
- **EMIT:**
  - `dst_valid`=1. `dst_pixel` and `dst_last` are held stable until `dst_ready`.
  - On handshake, increment `pix_count` and go to IDLE.
- Stalls: a `dst_ready` stall holds EMIT indefinitely. No new input is accepted meanwhile (`src_ready`=0).
- Error flag: if `err_clr` and a timeout event occur in the same cycle, set wins.
- `shd_pixel` is registered from the captured input and is not altered between IDLE capture and the next capture.

## Timing
- Reset values: state IDLE, `src_ready`=1, `shd_start`=0, `shd_pixel`=0, `dst_valid`=0, `dst_pixel`=0, `dst_last`=0, `err_timeout`=0, `pix_count`=0, timeout counter 0.
- Accept at cycle N:
  - `shd_start` high at N+1.
  - Earliest done sample at N+2.
  - `dst_valid` at N+3.
  - With immediate `dst_ready`, the next accept is at N+4.
  - Minimum pitch is 4 cycles/pixel, plus shader latency beyond 1 cycle.
- Timeout path: `dst_valid` is asserted exactly TIMEOUT+2 cycles after acceptance.
- Reset asserted mid-operation (any state) returns to IDLE immediately and drops `dst_valid` and `shd_start`. The pending pixel is discarded and not counted.
- All outputs are registered. There is no combinational path from inputs to outputs except `src_ready`, which is a decode of state only.

## Structure
- Shared package `r6x_gfx_pkg`:
  - State enum (IDLE/ISSUE/WAIT/EMIT).
  - Default PIX_W.
  - Default TIMEOUT.
- Single module. The timeout counter is inline; it is too small to justify a sub-module.
- Top level instantiates it in front of `shader_unit`.

## Test plan
- Basic: `src_pixel`=0x40. Model shader returns 0x54 with done 2 cycles after start. Required: one `shd_start` pulse, then `dst_pixel`=0x54, `pix_count`=1, `err_timeout`=0.
- Backpressure: `dst_ready`=0 for 10 cycles after `dst_valid`. Required: `dst_pixel`/`dst_last` stable, `src_ready`=0 throughout, one handshake only, `pix_count`=1.
- Timeout: TIMEOUT=8, shader never asserts done, `src_pixel`=0xA5. Required: `dst_pixel`=0xA5 exactly 10 cycles after accept, `err_timeout`=1 until `err_clr`.
- Stale done: `shd_done` held at 1 continuously. Required: done ignored in the ISSUE cycle and accepted in the first WAIT cycle. A stream of 4 pixels yields 4 outputs, each at 4-cycle pitch.
- Line end: 3 pixels with `src_last` on the third. Required: `dst_last`=1 only on the third output. With CNT_W=2 and 5 pixels, `pix_count` wraps to 1.
- Reset mid-WAIT: assert `rst` while waiting. Required: `dst_valid`=0, state IDLE, `pix_count` unchanged at 0, `src_ready`=1 on the first cycle after release.
